// File: rtl/bus_interconnect.sv
// Round-robin arbitrated, address-decoded interconnect between bus masters and slaves,
// with an error response for unmapped regions and a per-transfer timeout.
module bus_interconnect #(
    parameter int N_MASTERS = 2,
    parameter int N_SLAVES  = 4,
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int DEC_HI    = 31,
    parameter int DEC_LO    = 28,
    parameter logic [N_SLAVES*(DEC_HI-DEC_LO+1)-1:0] SLAVE_BASE = {4'h3, 4'h2, 4'h1, 4'hF},
    parameter int TIMEOUT   = 255
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_MASTERS-1:0]        m_breq,
    output logic [N_MASTERS-1:0]        m_bgnt,
    input  logic [N_MASTERS-1:0]        m_bstart,
    input  logic [N_MASTERS-1:0]        m_we,
    input  logic [N_MASTERS*ADDR_W-1:0] m_addr,
    input  logic [N_MASTERS*DATA_W-1:0] m_wdata,
    input  logic [N_MASTERS*2-1:0]      m_tsize,
    output logic [N_MASTERS*DATA_W-1:0] m_rdata,
    output logic [N_MASTERS-1:0]        m_bdone,
    output logic [N_MASTERS-1:0]        m_berror,
    output logic [N_SLAVES-1:0]         s_ss,
    output logic                        s_bstart,
    output logic                        s_we,
    output logic [ADDR_W-1:0]           s_addr,
    output logic [DATA_W-1:0]           s_wdata,
    output logic [1:0]                  s_tsize,
    input  logic [N_SLAVES*DATA_W-1:0]  s_rdata,
    input  logic [N_SLAVES-1:0]         s_bdone,
    input  logic [N_SLAVES-1:0]         s_berror
);
    localparam int RW = DEC_HI - DEC_LO + 1;
    localparam int MW = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
    localparam int SW = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);
    localparam logic [MW-1:0] MLAST = MW'(N_MASTERS - 1);

    typedef enum logic [1:0] {IDLE, GRANTED, XFER, DERR} state_t;

    state_t            state;
    logic [MW-1:0]     owner;
    logic [MW-1:0]     rr_ptr;
    logic [MW-1:0]     pick;
    logic [SW-1:0]     sel;
    logic [SW-1:0]     hit_idx;
    logic [SW-1:0]     fwd_sel;
    logic [TW-1:0]     tcnt;
    logic              hit;
    logic              fwd;
    logic              timeout;
    logic [ADDR_W-1:0] own_addr;

    // First requester at or after ptr, wrapping.
    function automatic logic [MW-1:0] rr_pick(input logic [N_MASTERS-1:0] req,
                                              input logic [MW-1:0] ptr);
        logic [MW-1:0] r;
        int idx;
        r = ptr;
        for (int i = N_MASTERS - 1; i >= 0; i--) begin
            idx = (int'(ptr) + i) % N_MASTERS;
            if (req[idx]) r = MW'(idx);
        end
        return r;
    endfunction

    // {hit, index}; lowest matching slave index wins.
    function automatic logic [SW:0] decode(input logic [RW-1:0] region);
        logic [SW:0] r;
        r = '0;
        for (int i = N_SLAVES - 1; i >= 0; i--) begin
            if (SLAVE_BASE[i*RW +: RW] == region) r = {1'b1, SW'(i)};
        end
        return r;
    endfunction

    always_comb begin
        own_addr       = m_addr[owner*ADDR_W +: ADDR_W];
        {hit, hit_idx} = decode(own_addr[DEC_HI:DEC_LO]);
        pick           = rr_pick(m_breq, rr_ptr);
        timeout        = (tcnt == TLAST);
    end

    // The bstart cycle of a mapped transfer is forwarded immediately so a
    // zero-wait slave can complete in the same cycle.
    always_comb begin
        m_rdata  = '0;
        m_bdone  = '0;
        m_berror = '0;
        s_ss     = '0;
        s_bstart = 1'b0;
        s_we     = 1'b0;
        s_addr   = '0;
        s_wdata  = '0;
        s_tsize  = '0;
        fwd      = 1'b0;
        fwd_sel  = sel;
        case (state)
            GRANTED: begin
                if (m_bstart[owner] && hit) begin
                    fwd      = 1'b1;
                    fwd_sel  = hit_idx;
                    s_bstart = 1'b1;
                end
            end
            XFER: fwd = 1'b1;
            DERR: begin
                m_bdone[owner]  = 1'b1;
                m_berror[owner] = 1'b1;
            end
            default: ;
        endcase
        if (fwd) begin
            s_ss[fwd_sel] = 1'b1;
            s_we          = m_we[owner];
            s_addr        = own_addr;
            s_wdata       = m_wdata[owner*DATA_W +: DATA_W];
            s_tsize       = m_tsize[owner*2 +: 2];
            m_rdata[owner*DATA_W +: DATA_W] = s_rdata[fwd_sel*DATA_W +: DATA_W];
            m_bdone[owner]  = s_bdone[fwd_sel];
            m_berror[owner] = s_bdone[fwd_sel] & s_berror[fwd_sel];
            if (state == XFER && timeout && !s_bdone[sel]) begin
                m_bdone[owner]  = 1'b1;
                m_berror[owner] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            owner  <= '0;
            rr_ptr <= '0;
            sel    <= '0;
            tcnt   <= '0;
            m_bgnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|m_breq) begin
                        owner  <= pick;
                        m_bgnt <= N_MASTERS'(1) << pick;
                        state  <= GRANTED;
                    end
                end
                GRANTED: begin
                    // A start always beats a simultaneous request drop.
                    if (m_bstart[owner]) begin
                        if (hit) begin
                            sel  <= hit_idx;
                            tcnt <= '0;
                            if (!s_bdone[hit_idx]) state <= XFER;
                        end else begin
                            state <= DERR;
                        end
                    end else if (!m_breq[owner]) begin
                        m_bgnt <= '0;
                        rr_ptr <= (owner == MLAST) ? '0 : owner + 1'b1;
                        state  <= IDLE;
                    end
                end
                XFER: begin
                    tcnt <= tcnt + 1'b1;
                    if (s_bdone[sel] || timeout) state <= GRANTED;
                end
                DERR: state <= GRANTED;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_interconnect.sv
// Self-checking bench for bus_interconnect: scripted and randomized transfers checked
// against a transaction-level reference model of arbitration, decode and timeout.
module tb_bus_interconnect;
    localparam int NM = 2;
    localparam int NS = 4;
    localparam int TO = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic [1:0]   m_breq, m_bgnt, m_bstart, m_we, m_bdone, m_berror;
    logic [63:0]  m_addr, m_wdata, m_rdata;
    logic [3:0]   m_tsize;
    logic [3:0]   s_ss, s_bdone, s_berror;
    logic         s_bstart, s_we;
    logic [31:0]  s_addr, s_wdata;
    logic [1:0]   s_tsize;
    logic [127:0] s_rdata;

    int errors = 0;
    int checks = 0;
    int exp_ptr = 0;
    logic [3:0] base_tab [4] = '{4'hF, 4'h1, 4'h2, 4'h3};

    bus_interconnect #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .m_breq(m_breq), .m_bgnt(m_bgnt), .m_bstart(m_bstart), .m_we(m_we),
        .m_addr(m_addr), .m_wdata(m_wdata), .m_tsize(m_tsize),
        .m_rdata(m_rdata), .m_bdone(m_bdone), .m_berror(m_berror),
        .s_ss(s_ss), .s_bstart(s_bstart), .s_we(s_we), .s_addr(s_addr),
        .s_wdata(s_wdata), .s_tsize(s_tsize),
        .s_rdata(s_rdata), .s_bdone(s_bdone), .s_berror(s_berror)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running, want finish");
        $fatal(1);
    end

    function automatic logic [1:0] m1h(input int m);
        return 2'(1 << m);
    endfunction

    function automatic logic [3:0] s1h(input int s);
        return 4'(1 << s);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic arbitrate(input logic [1:0] req, output int own);
        m_breq = req;
        m_bstart = '0;
        #1;
        checks++;
        if (m_bgnt !== 2'b00) begin errors++; $display("FAIL idle_gnt: got %b want 00", m_bgnt); end
        tick();
        own = -1;
        for (int i = 0; i < NM; i++)
            if (own < 0 && req[(exp_ptr + i) % NM]) own = (exp_ptr + i) % NM;
        checks++;
        if (m_bgnt !== ((own < 0) ? 2'b00 : m1h(own))) begin
            errors++; $display("FAIL grant: got %b want owner %0d (req %b)", m_bgnt, own, req);
        end
    endtask

    task automatic release_bus(input int own);
        m_breq[own] = 1'b0;
        m_bstart = '0;
        tick();
        checks++;
        if (m_bgnt !== 2'b00) begin errors++; $display("FAIL release: got %b want 00", m_bgnt); end
        exp_ptr = (own + 1) % NM;
    endtask

    task automatic check_quiet(input int m);
        m_bstart = '0;
        s_bdone = 4'($urandom);
        s_berror = 4'($urandom);
        #1;
        checks++;
        if (s_ss !== 4'b0 || s_bstart !== 1'b0 || s_addr !== 32'h0 || s_wdata !== 32'h0) begin
            errors++; $display("FAIL quiet_slave: got ss=%b bstart=%b addr=%h want all zero", s_ss, s_bstart, s_addr);
        end
        checks++;
        if (m_bdone !== 2'b00 || m_berror !== 2'b00 || m_bgnt !== m1h(m)) begin
            errors++; $display("FAIL quiet_master: got bdone=%b berror=%b bgnt=%b want 00 00 %b", m_bdone, m_berror, m_bgnt, m1h(m));
        end
        tick();
        s_bdone = '0;
    endtask

    // Owner m issues one transfer; slave responds lat cycles after bstart (0 = same cycle).
    task automatic do_xfer(input int m, input logic [31:0] addr, input logic we, input int lat,
                           input logic [31:0] rd, input logic serr);
        int slv, done_k;
        logic exp_err;
        logic [31:0] wd, exp_a, exp_w, exp_rd;
        logic [1:0] ts, exp_ts, exp_done, exp_berr;
        logic [3:0] exp_ss;
        logic exp_we;
        wd = $urandom;
        ts = 2'($urandom);
        slv = -1;
        for (int i = NS - 1; i >= 0; i--) if (base_tab[i] == addr[31:28]) slv = i;
        if (slv < 0) begin done_k = 1; exp_err = 1'b1; end
        else if (lat <= TO) begin done_k = lat; exp_err = serr; end
        else begin done_k = TO; exp_err = 1'b1; end
        exp_ss = (slv < 0) ? 4'b0 : s1h(slv);
        exp_a  = (slv < 0) ? 32'h0 : addr;
        exp_w  = (slv < 0) ? 32'h0 : wd;
        exp_we = (slv < 0) ? 1'b0 : we;
        exp_ts = (slv < 0) ? 2'b0 : ts;
        exp_rd = (slv < 0) ? 32'h0 : rd;
        for (int k = 0; k <= done_k; k++) begin
            m_addr = {$urandom, $urandom};   m_addr[m*32 +: 32] = addr;
            m_wdata = {$urandom, $urandom};  m_wdata[m*32 +: 32] = wd;
            m_we = 2'($urandom);             m_we[m] = we;
            m_tsize = 4'($urandom);          m_tsize[m*2 +: 2] = ts;
            m_bstart = 2'($urandom);
            if (k == 0) m_bstart[m] = 1'b1;
            for (int j = 0; j < NS; j++) s_rdata[j*32 +: 32] = $urandom;
            s_bdone = 4'($urandom);
            s_berror = 4'($urandom);
            if (slv >= 0) begin
                s_rdata[slv*32 +: 32] = rd;
                s_bdone[slv] = (k == lat);
                s_berror[slv] = serr;
            end
            #1;
            exp_done = (k == done_k) ? m1h(m) : 2'b00;
            exp_berr = (k == done_k && exp_err) ? m1h(m) : 2'b00;
            checks++;
            if (m_bgnt !== m1h(m)) begin errors++; $display("FAIL xfer_gnt k=%0d: got %b want %b", k, m_bgnt, m1h(m)); end
            checks++;
            if (s_ss !== exp_ss) begin errors++; $display("FAIL xfer_ss k=%0d addr=%h: got %b want %b", k, addr, s_ss, exp_ss); end
            checks++;
            if (s_bstart !== (slv >= 0 && k == 0)) begin errors++; $display("FAIL xfer_sbstart k=%0d: got %b", k, s_bstart); end
            checks++;
            if ({s_we, s_addr, s_wdata, s_tsize} !== {exp_we, exp_a, exp_w, exp_ts}) begin
                errors++; $display("FAIL xfer_fwd k=%0d: got %b %h %h %b want %b %h %h %b", k, s_we, s_addr, s_wdata, s_tsize, exp_we, exp_a, exp_w, exp_ts);
            end
            checks++;
            if (m_bdone !== exp_done) begin errors++; $display("FAIL xfer_bdone k=%0d addr=%h lat=%0d: got %b want %b", k, addr, lat, m_bdone, exp_done); end
            checks++;
            if (m_berror !== exp_berr) begin errors++; $display("FAIL xfer_berror k=%0d addr=%h lat=%0d: got %b want %b", k, addr, lat, m_berror, exp_berr); end
            checks++;
            if (m_rdata[(1-m)*32 +: 32] !== 32'h0) begin errors++; $display("FAIL xfer_rdata_nonowner k=%0d: got %h want 0", k, m_rdata[(1-m)*32 +: 32]); end
            if (k == done_k && (slv < 0 || lat <= TO)) begin
                checks++;
                if (m_rdata[m*32 +: 32] !== exp_rd) begin errors++; $display("FAIL xfer_rdata: got %h want %h", m_rdata[m*32 +: 32], exp_rd); end
            end
            tick();
        end
        m_bstart = '0;
        s_bdone = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        m_breq = 2'b11;
        m_bstart = 2'b11;
        m_addr = {$urandom, $urandom};
        s_bdone = 4'hF;
        tick();
        tick();
        checks++;
        if ({m_bgnt, m_bdone, m_berror, s_ss, s_bstart, s_we} !== 12'h0) begin
            errors++; $display("FAIL reset_ctrl: got bgnt=%b bdone=%b berror=%b ss=%b sbstart=%b", m_bgnt, m_bdone, m_berror, s_ss, s_bstart);
        end
        checks++;
        if ({s_addr, s_wdata, s_tsize, m_rdata} !== '0) begin
            errors++; $display("FAIL reset_data: got addr=%h wdata=%h rdata=%h want 0", s_addr, s_wdata, m_rdata);
        end
        m_breq = '0;
        m_bstart = '0;
        s_bdone = '0;
        rst = 1'b0;
        exp_ptr = 0;
        tick();
    endtask

    task automatic test_single_read();
        int own;
        arbitrate(2'b01, own);
        do_xfer(0, 32'hF000_0010, 1'b0, 2, 32'hDEAD_BEEF, 1'b0);
        check_quiet(0);
        release_bus(0);
    endtask

    task automatic test_contention();
        int own;
        for (int r = 0; r < 4; r++) begin
            arbitrate(2'b11, own);
            do_xfer(own, {4'h1, 28'($urandom)}, 1'($urandom), 1, $urandom, 1'b0);
            release_bus(own);
        end
    endtask

    task automatic test_unmapped();
        int own;
        arbitrate(2'b10, own);
        do_xfer(own, 32'h7000_0000, 1'b0, 3, $urandom, 1'b0);
        check_quiet(own);
        release_bus(own);
    endtask

    task automatic test_timeout();
        int own;
        arbitrate(2'b01, own);
        do_xfer(own, 32'h2000_0040, 1'b1, 100, $urandom, 1'b0);
        check_quiet(own);
        do_xfer(own, 32'h3000_0000, 1'b0, TO, 32'h1234_5678, 1'b0);
        check_quiet(own);
        release_bus(own);
    endtask

    task automatic test_back_to_back();
        int own;
        arbitrate(2'b10, own);
        do_xfer(own, 32'hF000_0000, 1'b0, 0, 32'hA5A5_5A5A, 1'b0);
        do_xfer(own, 32'h1000_0004, 1'b1, 0, $urandom, 1'b1);
        do_xfer(own, 32'h2000_0008, 1'b0, 3, 32'h0BAD_F00D, 1'b1);
        do_xfer(own, 32'hC000_0000, 1'b0, 1, $urandom, 1'b0);
        check_quiet(own);
        release_bus(own);
    endtask

    task automatic test_reset_mid_xfer();
        int own;
        arbitrate(2'b01, own);
        release_bus(own);
        arbitrate(2'b10, own);
        m_addr[32 +: 32] = 32'h1000_0000;
        m_bstart = 2'b10;
        s_bdone = '0;
        tick();
        m_bstart = '0;
        tick();
        tick();
        rst = 1'b1;
        #1;
        checks++;
        if (m_bdone !== 2'b00) begin errors++; $display("FAIL rst_xfer_bdone: got %b want 00", m_bdone); end
        tick();
        checks++;
        if ({m_bgnt, m_bdone, m_berror, s_ss, s_bstart} !== 11'h0 || s_addr !== 32'h0 || m_rdata !== 64'h0) begin
            errors++; $display("FAIL rst_xfer_outputs: got bgnt=%b bdone=%b ss=%b addr=%h", m_bgnt, m_bdone, s_ss, s_addr);
        end
        rst = 1'b0;
        m_breq = '0;
        exp_ptr = 0;
        tick();
        arbitrate(2'b11, own);
        release_bus(own);
    endtask

    task automatic test_random();
        int own, ntx, r, lat;
        logic [3:0] region;
        for (int t = 0; t < 20; t++) begin
            arbitrate(2'($urandom_range(1, 3)), own);
            if (own < 0) continue;
            ntx = $urandom_range(1, 3);
            for (int n = 0; n < ntx; n++) begin
                r = $urandom_range(0, 5);
                region = (r < 4) ? base_tab[r] : 4'($urandom_range(4, 14));
                lat = $urandom_range(0, TO + 2);
                do_xfer(own, {region, 28'($urandom)}, 1'($urandom), lat, $urandom, 1'($urandom));
            end
            release_bus(own);
        end
    endtask

    initial begin
        rst = 1'b1;
        m_breq = '0; m_bstart = '0; m_we = '0; m_addr = '0; m_wdata = '0; m_tsize = '0;
        s_rdata = '0; s_bdone = '0; s_berror = '0;
        tick();
        test_reset();
        test_single_read();
        test_contention();
        test_unmapped();
        test_timeout();
        test_back_to_back();
        test_reset_mid_xfer();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
